// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer in the reference-clock domain.
// Pulses the PLL reset, waits for a synchronized lock with a timeout, requires
// the lock to hold for a stable window, then releases the system reset.
// Lock timeouts retry up to a budget and then park in a sticky FAIL state.
// Lock loss while running restarts the sequence and is counted.
//
// Outputs are registered and decoded from the next state, so they change on
// the same edge as the state register. state_dbg exposes the FSM state for
// checkers: 0=ASSERT 1=WAIT_LOCK 2=STABLE 3=RUN 4=FAIL.
module pll_reset_sequencer #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       retry_req,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [7:0] retry_count,
    output logic [7:0] loss_count,
    output logic [2:0] state_dbg
);

    // One shared cycle counter serves the pulse, timeout and stable windows.
    localparam int MAX_A   = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_CNT = (MAX_A > LOCK_STABLE_CYCLES) ? MAX_A : LOCK_STABLE_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] PULSE_LAST   = CW'(RST_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);

    typedef enum logic [2:0] {
        ST_ASSERT    = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    retry_q, retry_d;
    logic [7:0]    loss_q, loss_d;
    logic          meta_q, locked_s_q;
    logic          pll_rst_q, sys_rst_q, ready_q, fail_q;

    // Two-flop synchronizer for the asynchronous lock indicator.
    always_ff @(posedge refclk) begin
        if (rst) begin
            meta_q     <= 1'b0;
            locked_s_q <= 1'b0;
        end else begin
            meta_q     <= pll_locked;
            locked_s_q <= meta_q;
        end
    end

    // Next-state and counter logic for the bring-up sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        case (state_q)
            ST_ASSERT: begin
                if (cnt_q >= PULSE_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT_LOCK: begin
                if (locked_s_q) begin
                    state_d = ST_STABLE;
                    cnt_d   = CNT_ONE;
                end else if (cnt_q >= TIMEOUT_LAST) begin
                    // Counter stops here; the attempt is over either way.
                    cnt_d = '0;
                    if (int'(retry_q) >= MAX_RETRIES) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d = ST_ASSERT;
                        retry_d = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_STABLE: begin
                if (!locked_s_q) begin
                    // A glitch restarts the lock wait but does not spend a retry.
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q >= STABLE_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_RUN: begin
                if (!locked_s_q) begin
                    state_d = ST_ASSERT;
                    cnt_d   = '0;
                    retry_d = 8'd0;
                    loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
                end
            end
            ST_FAIL: begin
                if (retry_req) begin
                    state_d = ST_ASSERT;
                    cnt_d   = '0;
                    retry_d = 8'd0;
                end
            end
            default: begin
                state_d = ST_ASSERT;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counters and next-state-decoded output registers; rst wins over everything.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= ST_ASSERT;
            cnt_q     <= '0;
            retry_q   <= 8'd0;
            loss_q    <= 8'd0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            loss_q    <= loss_d;
            pll_rst_q <= (state_d == ST_ASSERT) || (state_d == ST_FAIL);
            sys_rst_q <= (state_d != ST_RUN);
            ready_q   <= (state_d == ST_RUN);
            fail_q    <= (state_d == ST_FAIL);
        end
    end

    assign pll_rst     = pll_rst_q;
    assign sys_rst     = sys_rst_q;
    assign ready       = ready_q;
    assign fail        = fail_q;
    assign retry_count = retry_q;
    assign loss_count  = loss_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with params 4/20/8/2.
// Expected output snapshots and latencies are queued before each step and
// popped when the DUT reaches the point being checked.
module tb_pll_reset_sequencer;

    localparam int P = 4;
    localparam int T = 20;
    localparam int S = 8;
    localparam int M = 2;

    localparam int W_PRST_LO = 0;
    localparam int W_PRST_HI = 1;
    localparam int W_READY   = 2;
    localparam int W_SRST_HI = 3;
    localparam int W_FAIL    = 4;

    logic       refclk     = 1'b0;
    logic       rst        = 1'b1;
    logic       pll_locked = 1'b0;
    logic       retry_req  = 1'b0;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fail;
    logic [7:0] retry_count;
    logic [7:0] loss_count;
    logic [2:0] state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    logic [19:0] exp_q[$];
    string       tag_q[$];
    int          lat_q[$];
    string       lat_tag_q[$];

    pll_reset_sequencer #(
        .RST_PULSE_CYCLES   (P),
        .LOCK_TIMEOUT_CYCLES(T),
        .LOCK_STABLE_CYCLES (S),
        .MAX_RETRIES        (M)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .retry_req  (retry_req),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .fail       (fail),
        .retry_count(retry_count),
        .loss_count (loss_count),
        .state_dbg  (state_dbg)
    );

    // 50 MHz reference clock
    always #10 refclk = ~refclk;

    wire [19:0] obs_vec = {pll_rst, sys_rst, ready, fail, retry_count, loss_count};

    function automatic logic [19:0] pack(input logic pr, input logic sr, input logic rd,
                                         input logic fl, input logic [7:0] rc, input logic [7:0] lc);
        return {pr, sr, rd, fl, rc, lc};
    endfunction

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic expect_vec(input string tag, input logic [19:0] e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check_vec();
        logic [19:0] e;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_tests++;
        assert (obs_vec === e) else begin
            n_fail++;
            $error("FAIL %s: observed {pll_rst,sys_rst,ready,fail,rc,lc}=%h expected %h", t, obs_vec, e);
        end
    endtask

    task automatic expect_int(input string tag, input int e);
        lat_q.push_back(e);
        lat_tag_q.push_back(tag);
    endtask

    task automatic check_int(input int obs);
        int    e;
        string t;
        e = lat_q.pop_front();
        t = lat_tag_q.pop_front();
        n_tests++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", t, obs, e);
        end
    endtask

    function automatic logic cond(input int which);
        case (which)
            W_PRST_LO: return (pll_rst === 1'b0);
            W_PRST_HI: return (pll_rst === 1'b1);
            W_READY:   return (ready === 1'b1);
            W_SRST_HI: return (sys_rst === 1'b1);
            W_FAIL:    return (fail === 1'b1);
            default:   return 1'b0;
        endcase
    endfunction

    // Counts clock cycles until the condition holds; -1 if the budget runs out.
    task automatic wait_until(input int which, output int n);
        n = 0;
        while (!cond(which) && n < 200) begin
            tick();
            n++;
        end
        if (!cond(which)) n = -1;
    endtask

    initial begin
        int n;

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        expect_vec("reset", pack(1, 1, 0, 0, 8'd0, 8'd0));
        check_vec();
        expect_int("reset_state", 0);
        check_int(int'(state_dbg));

        // Normal bring-up
        rst = 1'b0;
        expect_int("pulse_len_initial", P);
        wait_until(W_PRST_LO, n);
        check_int(n);
        repeat (4) tick();
        pll_locked = 1'b1;
        expect_int("lock_to_ready", S + 2);
        wait_until(W_READY, n);
        check_int(n);
        expect_vec("run_after_bringup", pack(0, 0, 1, 0, 8'd0, 8'd0));
        check_vec();

        // retry_req has no effect outside FAIL
        retry_req = 1'b1;
        tick();
        retry_req = 1'b0;
        tick();
        expect_vec("retry_req_ignored_in_run", pack(0, 0, 1, 0, 8'd0, 8'd0));
        check_vec();

        // Lock loss in RUN and relock
        pll_locked = 1'b0;
        expect_int("loss_to_sys_rst", 3);
        wait_until(W_SRST_HI, n);
        check_int(n);
        expect_vec("after_loss", pack(1, 1, 0, 0, 8'd0, 8'd1));
        check_vec();
        expect_int("pulse_len_after_loss", P);
        wait_until(W_PRST_LO, n);
        check_int(n);
        pll_locked = 1'b1;
        expect_int("relock_to_ready", S + 2);
        wait_until(W_READY, n);
        check_int(n);
        expect_vec("run_after_relock", pack(0, 0, 1, 0, 8'd0, 8'd1));
        check_vec();

        // Second loss, then lock never returns: retry budget runs out
        pll_locked = 1'b0;
        expect_int("loss2_to_sys_rst", 3);
        wait_until(W_SRST_HI, n);
        check_int(n);
        expect_int("assert_to_fail", (M + 1) * (P + T));
        wait_until(W_FAIL, n);
        check_int(n);
        expect_vec("fail_state", pack(1, 1, 0, 1, 8'd2, 8'd2));
        check_vec();
        repeat (30) tick();
        expect_vec("fail_sticky", pack(1, 1, 0, 1, 8'd2, 8'd2));
        check_vec();

        // retry_req leaves FAIL, keeps loss_count, clears retry_count
        retry_req = 1'b1;
        tick();
        retry_req = 1'b0;
        expect_vec("retry_req_from_fail", pack(1, 1, 0, 0, 8'd0, 8'd2));
        check_vec();
        expect_int("retry_state", 0);
        check_int(int'(state_dbg));
        expect_int("retry_to_fail", (M + 1) * (P + T));
        wait_until(W_FAIL, n);
        check_int(n);

        // rst together with retry_req in FAIL: reset wins and clears loss_count
        rst       = 1'b1;
        retry_req = 1'b1;
        tick();
        retry_req = 1'b0;
        expect_vec("rst_with_retry_in_fail", pack(1, 1, 0, 0, 8'd0, 8'd0));
        check_vec();
        rst = 1'b0;

        // Timeout with recovery on the second attempt
        expect_int("pulse_len_t5", P);
        wait_until(W_PRST_LO, n);
        check_int(n);
        expect_int("timeout_len", T);
        wait_until(W_PRST_HI, n);
        check_int(n);
        expect_vec("after_timeout", pack(1, 1, 0, 0, 8'd1, 8'd0));
        check_vec();
        expect_int("pulse_len_retry", P);
        wait_until(W_PRST_LO, n);
        check_int(n);
        pll_locked = 1'b1;
        expect_int("retry_lock_to_ready", S + 2);
        wait_until(W_READY, n);
        check_int(n);
        expect_vec("run_after_retry", pack(0, 0, 1, 0, 8'd1, 8'd0));
        check_vec();

        // One-cycle glitch during STABLE restarts the stable window
        pll_locked = 1'b0;
        rst        = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        expect_int("pulse_len_t6", P);
        wait_until(W_PRST_LO, n);
        check_int(n);
        pll_locked = 1'b1;
        repeat (5) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        expect_int("glitch_to_ready", S + 2);
        wait_until(W_READY, n);
        check_int(n);
        expect_vec("run_after_glitch", pack(0, 0, 1, 0, 8'd0, 8'd0));
        check_vec();

        // Reset in the middle of STABLE
        pll_locked = 1'b0;
        expect_int("loss3_to_sys_rst", 3);
        wait_until(W_SRST_HI, n);
        check_int(n);
        pll_locked = 1'b1;
        repeat (6) tick();
        expect_vec("mid_stable", pack(0, 1, 0, 0, 8'd0, 8'd1));
        check_vec();
        expect_int("mid_stable_state", 2);
        check_int(int'(state_dbg));
        rst = 1'b1;
        tick();
        expect_vec("rst_mid_stable", pack(1, 1, 0, 0, 8'd0, 8'd0));
        check_vec();
        expect_int("rst_mid_stable_state", 0);
        check_int(int'(state_dbg));
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
